// File: rtl/trace_playback_ctrl_pkg.sv
// Shared widths and controller state encoding for the trace playback slice.
package trace_playback_ctrl_pkg;

  localparam int TPC_ADDR_W = 15;
  localparam int TPC_DATA_W = 4;
  localparam int TPC_RPT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/trace_playback_ctrl_if.sv
// Configuration, trace-memory and trace-output signals of the playback controller.
interface trace_playback_ctrl_if
  import trace_playback_ctrl_pkg::*;
#(
  parameter int ADDR_W = TPC_ADDR_W,
  parameter int DATA_W = TPC_DATA_W,
  parameter int RPT_W  = TPC_RPT_W
);

  logic [ADDR_W-1:0] cfg_start_addr;
  logic [ADDR_W:0]   cfg_length;
  logic [RPT_W-1:0]  cfg_repeat;
  logic [DATA_W-1:0] cfg_idle;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] TRACEDATA;
  logic              trace_valid;
  logic              busy;
  logic              done;
  logic [RPT_W-1:0]  pass_cnt;

  modport slave (
    input  cfg_start_addr, cfg_length, cfg_repeat, cfg_idle, start, abort, mem_data,
    output mem_addr, mem_rd, TRACEDATA, trace_valid, busy, done, pass_cnt
  );

  modport master (
    output cfg_start_addr, cfg_length, cfg_repeat, cfg_idle, start, abort, mem_data,
    input  mem_addr, mem_rd, TRACEDATA, trace_valid, busy, done, pass_cnt
  );

endinterface

// File: rtl/trace_playback_ctrl_addr_gen.sv
// Window address counter: walks start..start+length-1 (mod 2^ADDR_W) and rewinds for each pass.
module trace_addr_gen
  import trace_playback_ctrl_pkg::*;
#(
  parameter int ADDR_W = TPC_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W:0]   length_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_read_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;

  assign addr_o      = addr_q;
  assign last_read_o = (idx_q == len_q - LEN_ONE);

  always_comb begin
    addr_d = addr_q;
    base_d = base_q;
    len_d  = len_q;
    idx_d  = idx_q;
    if (load_i) begin
      base_d = start_addr_i;
      len_d  = length_i;
      addr_d = start_addr_i;
      idx_d  = '0;
    end else if (advance_i) begin
      if (last_read_o) begin
        addr_d = base_q;
        idx_d  = '0;
      end else begin
        addr_d = addr_q + ADDR_ONE;
        idx_d  = idx_q + LEN_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else begin
      addr_q <= addr_d;
      base_q <= base_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/trace_playback_ctrl.sv
// Trace playback controller: streams a window of trace memory onto TRACEDATA with repeat/abort,
// driving the idle nibble whenever no memory data is being presented.
module trace_playback_ctrl
  import trace_playback_ctrl_pkg::*;
#(
  parameter int ADDR_W = TPC_ADDR_W,
  parameter int DATA_W = TPC_DATA_W,
  parameter int RPT_W  = TPC_RPT_W
) (
  input logic                  clk,
  input logic                  reset,
  trace_playback_ctrl_if.slave bus
);

  localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

  state_e            state_q, state_d;
  logic              drain_q, drain_d;
  logic [RPT_W-1:0]  rpt_q, rpt_d;
  logic [RPT_W-1:0]  pass_q, pass_d;
  logic [DATA_W-1:0] idle_q, idle_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rd_dly_q, rd_dly_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              load, advance, last_read, final_read;
  logic [DATA_W-1:0] idle_sel;
  logic [ADDR_W-1:0] addr;

  trace_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load),
    .advance_i    (advance),
    .start_addr_i (bus.cfg_start_addr),
    .length_i     (bus.cfg_length),
    .addr_o       (addr),
    .last_read_o  (last_read)
  );

  assign bus.mem_addr    = addr;
  assign bus.mem_rd      = (state_q == ST_FETCH);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.TRACEDATA   = data_q;
  assign bus.trace_valid = valid_q;
  assign bus.done        = done_q;
  assign bus.pass_cnt    = pass_q;

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    rpt_d      = rpt_q;
    pass_d     = pass_q;
    idle_d     = idle_q;
    done_d     = 1'b0;
    load       = 1'b0;
    advance    = (state_q == ST_FETCH) && !bus.abort;
    final_read = last_read && (rpt_q != '0) && (pass_q == rpt_q - RPT_ONE);
    idle_sel   = (state_q == ST_IDLE) ? bus.cfg_idle : idle_q;

    // Abort kills the read pipeline so in-flight data never reaches TRACEDATA.
    rd_dly_d = (state_q == ST_FETCH) && !bus.abort;
    valid_d  = rd_dly_q && !bus.abort;
    data_d   = (rd_dly_q && !bus.abort) ? bus.mem_data : idle_sel;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          rpt_d  = bus.cfg_repeat;
          idle_d = bus.cfg_idle;
          pass_d = '0;
          if (bus.cfg_length == '0) begin
            done_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (last_read) begin
          pass_d = (pass_q == '1) ? pass_q : pass_q + RPT_ONE;
          if (final_read) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (drain_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      drain_q  <= 1'b0;
      rpt_q    <= '0;
      pass_q   <= '0;
      idle_q   <= '0;
      data_q   <= '0;
      rd_dly_q <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      rpt_q    <= rpt_d;
      pass_q   <= pass_d;
      idle_q   <= idle_d;
      data_q   <= data_d;
      rd_dly_q <= rd_dly_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_trace_playback_ctrl.sv
// Self-checking bench for trace_playback_ctrl: cycle-exact window/repeat/abort model plus a trace memory responder.
module tb_trace_playback_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [3:0] mem [0:32767];

  trace_playback_ctrl_if bus ();

  trace_playback_ctrl dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous trace memory: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
  end

  // Expected behaviour, relative to the start cycle (c=0):
  // reads at c=1..N, nibble k on TRACEDATA at c=k+3, done at N+3; abort at A cuts everything from A+1.
  task automatic run_window(input string name, input int sa, input int len, input int rpt,
                            input logic [3:0] idle, input int abortAt, input int startAt);
    int n, last, expPass;
    logic inRun, expRd, expBusy, expValid, expDone;
    logic [14:0] expAddr;
    logic [3:0]  expData;
    n = (len == 0) ? 0 : ((rpt == 0) ? (1 << 30) : len * rpt);
    last = (abortAt == 0) ? n + 4 : abortAt + 3;
    @(negedge clk);
    bus.cfg_start_addr = 15'(sa);
    bus.cfg_length     = 16'(len);
    bus.cfg_repeat     = 8'(rpt);
    bus.cfg_idle       = idle;
    bus.start          = 1'b1;
    bus.abort          = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      inRun    = (abortAt == 0) || (c <= abortAt);
      expRd    = (c <= n) && inRun;
      expBusy  = (len != 0) && (c <= n + 2) && inRun;
      expValid = (c >= 3) && (c <= n + 2) && inRun;
      expDone  = (len == 0) ? (c == 1) : ((c == n + 3) && (abortAt == 0));
      expAddr  = 15'((sa + ((c - 1) % ((len == 0) ? 1 : len))) % 32768);
      expData  = expValid ? mem[(sa + ((c - 3) % len)) % 32768] : idle;
      checks += 5;
      if (bus.mem_rd !== expRd) begin
        failures++;
        $display("[TB] FAIL %s c=%0d mem_rd got=%0b exp=%0b", name, c, bus.mem_rd, expRd);
      end
      if (bus.busy !== expBusy) begin
        failures++;
        $display("[TB] FAIL %s c=%0d busy got=%0b exp=%0b", name, c, bus.busy, expBusy);
      end
      if (bus.trace_valid !== expValid) begin
        failures++;
        $display("[TB] FAIL %s c=%0d trace_valid got=%0b exp=%0b", name, c, bus.trace_valid, expValid);
      end
      if (bus.TRACEDATA !== expData) begin
        failures++;
        $display("[TB] FAIL %s c=%0d TRACEDATA got=%h exp=%h", name, c, bus.TRACEDATA, expData);
      end
      if (bus.done !== expDone) begin
        failures++;
        $display("[TB] FAIL %s c=%0d done got=%0b exp=%0b", name, c, bus.done, expDone);
      end
      if (expRd) begin
        checks++;
        if (bus.mem_addr !== expAddr) begin
          failures++;
          $display("[TB] FAIL %s c=%0d mem_addr got=%h exp=%h", name, c, bus.mem_addr, expAddr);
        end
      end
      bus.start = (c == startAt);
      bus.abort = (c == abortAt);
      if (c == startAt) begin
        bus.cfg_start_addr = 15'($urandom);
        bus.cfg_length     = 16'($urandom_range(1, 9));
        bus.cfg_repeat     = 8'($urandom_range(1, 5));
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (len == 0) expPass = 0;
    else if (abortAt == 0 || abortAt > n) expPass = rpt;
    else expPass = ((abortAt - 1) / len > 255) ? 255 : (abortAt - 1) / len;
    checks++;
    if (int'(bus.pass_cnt) !== expPass) begin
      failures++;
      $display("[TB] FAIL %s pass_cnt got=%0d exp=%0d", name, bus.pass_cnt, expPass);
    end
  endtask

  task automatic test_reset();
    bus.cfg_start_addr = '0;
    bus.cfg_length     = '0;
    bus.cfg_repeat     = '0;
    bus.cfg_idle       = '0;
    bus.start          = 1'b0;
    bus.abort          = 1'b0;
    rst_n              = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_addr, bus.mem_rd, bus.TRACEDATA, bus.trace_valid, bus.busy, bus.done, bus.pass_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_values addr=%h rd=%0b data=%h valid=%0b busy=%0b done=%0b pass=%0d exp all zero",
               bus.mem_addr, bus.mem_rd, bus.TRACEDATA, bus.trace_valid, bus.busy, bus.done, bus.pass_cnt);
    end
    bus.cfg_idle = 4'hA;
    rst_n        = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.TRACEDATA !== 4'hA) begin
      failures++;
      $display("[TB] FAIL reset_idle TRACEDATA got=%h exp=a", bus.TRACEDATA);
    end
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle busy got=%0b exp=0", bus.busy);
    end
  endtask

  task automatic test_single_pass();
    for (int i = 0; i < 32768; i++) mem[i] = 4'(i);
    run_window("single_pass", 'h10, 4, 1, 4'hA, 0, 0);
  endtask

  task automatic test_repeat_wrap();
    run_window("repeat_wrap", 'h7FFE, 3, 2, 4'h5, 0, 0);
  endtask

  task automatic test_empty_window();
    run_window("empty_window", 'h123, 0, 3, 4'hC, 0, 0);
  endtask

  task automatic test_abort();
    run_window("abort_loop", 'h40, 8, 0, 4'h9, 10, 10);
    run_window("abort_drain", 'h200, 3, 1, 4'h6, 4, 0);
  endtask

  task automatic test_contention();
    @(negedge clk);
    bus.cfg_start_addr = 15'h0100;
    bus.cfg_length     = 16'd4;
    bus.cfg_repeat     = 8'd1;
    bus.cfg_idle       = 4'h3;
    bus.start          = 1'b1;
    bus.abort          = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      checks++;
      if (bus.mem_rd !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL start_abort_idle c=%0d rd=%0b busy=%0b done=%0b exp 0/0/0",
                 c, bus.mem_rd, bus.busy, bus.done);
      end
    end
    run_window("start_while_busy", 'h300, 4, 2, 4'h3, 0, 5);
  endtask

  task automatic test_saturation();
    run_window("pass_saturate", 'h0, 1, 0, 4'hE, 300, 0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    bus.cfg_start_addr = 15'h0050;
    bus.cfg_length     = 16'd5;
    bus.cfg_repeat     = 8'd2;
    bus.cfg_idle       = 4'h7;
    bus.start          = 1'b1;
    repeat (6) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_addr, bus.mem_rd, bus.TRACEDATA, bus.trace_valid, bus.busy, bus.done, bus.pass_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_run addr=%h rd=%0b data=%h valid=%0b busy=%0b pass=%0d exp all zero",
               bus.mem_addr, bus.mem_rd, bus.TRACEDATA, bus.trace_valid, bus.busy, bus.pass_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_rd !== 1'b0 || bus.busy !== 1'b0 || bus.TRACEDATA !== 4'h7) begin
        failures++;
        $display("[TB] FAIL after_reset c=%0d rd=%0b busy=%0b data=%h exp 0/0/7",
                 c, bus.mem_rd, bus.busy, bus.TRACEDATA);
      end
    end
  endtask

  task automatic test_random();
    int sa, len, rpt, n, abortAt, startAt;
    logic [3:0] idle;
    for (int i = 0; i < 32768; i++) mem[i] = 4'($urandom);
    for (int it = 0; it < 10; it++) begin
      sa = int'($urandom_range(0, 32767));
      if (it % 3 == 0) sa = 32768 - int'($urandom_range(1, 4));
      len  = int'($urandom_range(2, 6));
      rpt  = int'($urandom_range(1, 3));
      idle = 4'($urandom);
      n    = len * rpt;
      abortAt = 0;
      if (it % 2 == 1) begin
        abortAt = int'($urandom_range(2, n + 2));
        if (abortAt <= n && abortAt % len == 0) abortAt--;
      end
      startAt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n)) : 0;
      if (abortAt != 0 && startAt >= abortAt) startAt = 0;
      run_window("random", sa, len, rpt, idle, abortAt, startAt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_pass();
    test_repeat_wrap();
    test_empty_window();
    test_abort();
    test_contention();
    test_saturation();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
